// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
// Holds the sel/pc_sel command codes, the FSM state enum and small decode helpers.
package pipeline_ctrl_pkg;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_CLEAR = 2'b11;

  localparam logic [1:0] PC_ADVANCE  = 2'b00;
  localparam logic [1:0] PC_HOLD     = 2'b01;
  localparam logic [1:0] PC_REDIRECT = 2'b10;

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN      = S_RUN,
    ST_MEM_WAIT = S_MEM_WAIT
  } state_t;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic [1:0] if_id_sel;
    logic [1:0] id_ex_sel;
    logic [1:0] ex_mem_sel;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input logic [1:0] pc,
                                    input logic [1:0] if_id,
                                    input logic [1:0] id_ex,
                                    input logic [1:0] ex_mem);
    ctrl_t c;
    c.pc_sel     = pc;
    c.if_id_sel  = if_id;
    c.id_ex_sel  = id_ex;
    c.ex_mem_sel = ex_mem;
    return c;
  endfunction

  function automatic logic src_hit(input logic       use_src,
                                   input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: one cycle from inc to updated count, holds at all-ones.
// No backpressure; inc is sampled every cycle, synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: zero-latency pc/sel commands from state and inputs.
// Memory wait stalls everything; mispredict flushes; load-use bubbles; counters lag by one cycle.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic             ex_is_load_i,
  input  logic             ex_mispredict_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic [1:0]       pc_sel_o,
  output logic [1:0]       if_id_sel_o,
  output logic [1:0]       id_ex_sel_o,
  output logic [1:0]       ex_mem_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                timeout_q;

  logic                ld_hit;
  logic                mem_wait;
  logic                mispred;
  logic                load_use;
  ctrl_t               ctrl;

  assign ld_hit = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
                  (src_hit(id_rs1_use_i, id_rs1_addr_i, ex_rd_addr_i) ||
                   src_hit(id_rs2_use_i, id_rs2_addr_i, ex_rd_addr_i));

  assign mem_wait = ((state_q == ST_RUN) && mem_req_i && !dmem_ready_i) ||
                    ((state_q == ST_MEM_WAIT) && !dmem_ready_i);
  // A mispredict under a memory wait stays pending because EX is held with it.
  assign mispred  = ex_mispredict_i && !mem_wait;
  assign load_use = ld_hit && !mem_wait && !mispred;

  always_comb begin
    ctrl = mk_ctrl(PC_ADVANCE, SEL_LOAD, SEL_LOAD, SEL_LOAD);
    if (i_rst) begin
      ctrl = mk_ctrl(PC_ADVANCE, SEL_CLEAR, SEL_CLEAR, SEL_CLEAR);
    end else if (mem_wait) begin
      ctrl = mk_ctrl(PC_HOLD, SEL_HOLD, SEL_HOLD, SEL_HOLD);
    end else if (mispred) begin
      ctrl = mk_ctrl(PC_REDIRECT, SEL_CLEAR, SEL_CLEAR, SEL_LOAD);
    end else if (load_use) begin
      ctrl = mk_ctrl(PC_HOLD, SEL_HOLD, SEL_CLEAR, SEL_LOAD);
    end
  end

  assign pc_sel_o     = ctrl.pc_sel;
  assign if_id_sel_o  = ctrl.if_id_sel;
  assign id_ex_sel_o  = ctrl.id_ex_sel;
  assign ex_mem_sel_o = ctrl.ex_mem_sel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_req_i && !dmem_ready_i) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ready_i)               state_d = ST_RUN;
      default:                                     state_d = ST_RUN;
    endcase
  end

  // The request cycle itself counts as the first wait cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!mem_wait) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (mem_wait && (wait_cnt_q >= (WAIT_MAX - 1'b1))) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout_o = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (mem_wait || load_use),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (mispred),
    .cnt   (flush_cnt_o)
  );

endmodule
